// File: rtl/dmem_resp.sv
// dmem_resp: single-port 1024 x 32 data memory with a request/response FSM.
// A load or store is accepted in IDLE, performed in LOAD/STORE, and reported
// in DONE (ack/rvalid), so back-to-back requests are served every third cycle.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   mem_rw_i   - request type: 00 none, 01 load, 10 store, 11 reserved
//   mem_addr_i - byte address, word index = [11:2]
//   mem_sel_i  - byte-lane enables
//   mem_data_i - store data, lane-aligned
//   rdata_o    - load result with unselected lanes zeroed (held until next load)
//   rvalid_o   - one-cycle pulse with a new load result
//   ack_o      - one-cycle pulse when a load or store completes
//   err_o      - one-cycle pulse when a request is rejected
//   stallreq_o - combinational: hold the memory-stage request stable
module dmem_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_rw_i,
    input  logic [11:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stallreq_o
);

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 10;
    localparam int unsigned SW     = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DEPTH  = 1024;

    localparam logic [1:0] RW_LOAD  = 2'b01;
    localparam logic [1:0] RW_STORE = 2'b10;
    localparam logic [1:0] RW_RSVD  = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_LOAD  = 2'b01;
    localparam logic [1:0] S_STORE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] rdata_d;
    logic          rvalid_d, ack_d, err_d;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] lane_mask;
    logic [DW-1:0] rd_word;
    logic          req_load, req_store, req_err;
    logic          unused_addr_lsb;

    // Byte offset bits never affect the access.
    assign unused_addr_lsb = ^mem_addr_i[1:0];

    // Request classification; a zero lane mask makes a load/store invalid.
    assign req_load  = (mem_rw_i == RW_LOAD)  && (mem_sel_i != '0);
    assign req_store = (mem_rw_i == RW_STORE) && (mem_sel_i != '0);
    assign req_err   = (mem_rw_i == RW_RSVD) ||
                       (((mem_rw_i == RW_LOAD) || (mem_rw_i == RW_STORE)) && (mem_sel_i == '0));

    // Stall is gated by reset so it drops immediately when rst goes low.
    assign stallreq_o = rst & (((state_q == S_IDLE) & (req_load | req_store)) |
                               (state_q == S_LOAD) | (state_q == S_STORE));

    // Expand latched byte enables to a bit mask.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < int'(SW); i++) begin
            lane_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{sel_q[i]}};
        end
    end

    assign rd_word = mem[addr_q];

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        data_d   = data_q;
        rdata_d  = rdata_o;
        rvalid_d = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_load) begin
                    addr_d  = mem_addr_i[AW+1:2];
                    sel_d   = mem_sel_i;
                    state_d = S_LOAD;
                end else if (req_store) begin
                    addr_d  = mem_addr_i[AW+1:2];
                    sel_d   = mem_sel_i;
                    data_d  = mem_data_i;
                    state_d = S_STORE;
                end else if (req_err) begin
                    err_d = 1'b1;
                end
            end
            S_LOAD: begin
                rdata_d  = rd_word & lane_mask;
                rvalid_d = 1'b1;
                ack_d    = 1'b1;
                state_d  = S_DONE;
            end
            S_STORE: begin
                ack_d   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                // The completed request is still presented; ignore it.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched request and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            rdata_o  <= rdata_d;
            rvalid_o <= rvalid_d;
            ack_o    <= ack_d;
            err_o    <= err_d;
        end
    end

    // Storage is not reset; reset forces IDLE, which abandons a pending write.
    always_ff @(posedge clk) begin
        if (state_q == S_STORE) begin
            mem[addr_q] <= (rd_word & ~lane_mask) | (data_q & lane_mask);
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios plus randomized
// load/store traffic checked against a word-array reference model.
module tb_dmem_resp;

    logic        clk;
    logic        rst;
    logic [1:0]  mem_rw_i;
    logic [11:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        ack_o;
    logic        err_o;
    logic        stallreq_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] ref_mem [1024];
    logic [31:0] ref_rdata;

    typedef struct {
        logic [1:0]  rw;
        logic [11:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] exp;
    } op_t;

    dmem_resp dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rw_i   (mem_rw_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = sel[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Reference model: whole-word array, byte-lane merge on store.
    function automatic void ref_store(input logic [11:0] addr, input logic [3:0] sel,
                                      input logic [31:0] data);
        logic [31:0] m;
        m = byte_mask(sel);
        ref_mem[addr[11:2]] = (ref_mem[addr[11:2]] & ~m) | (data & m);
    endfunction

    function automatic logic [31:0] ref_load(input logic [11:0] addr, input logic [3:0] sel);
        ref_rdata = ref_mem[addr[11:2]] & byte_mask(sel);
        return ref_rdata;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        mem_rw_i   = 2'b00;
        mem_addr_i = 12'h000;
        mem_sel_i  = 4'h0;
        mem_data_i = 32'h0;
    endtask

    // One full request: present, hold through busy and DONE, then go idle.
    // tvec = {stall c0, stall c1, stall c2, ack c0, ack c1, ack c2, rvalid c2}
    task automatic do_op(input logic [1:0] rw, input logic [11:0] addr, input logic [3:0] sel,
                         input logic [31:0] data, output logic [6:0] tvec,
                         output logic [31:0] rd);
        mem_rw_i   = rw;
        mem_addr_i = addr;
        mem_sel_i  = sel;
        mem_data_i = data;
        #1;
        tvec[6] = stallreq_o;
        tvec[3] = ack_o;
        tick;
        tvec[5] = stallreq_o;
        tvec[2] = ack_o;
        tick;
        tvec[4] = stallreq_o;
        tvec[1] = ack_o;
        tvec[0] = rvalid_o;
        rd      = rdata_o;
        tick;
        idle_inputs;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs;
        mem_rw_i  = 2'b01;
        mem_sel_i = 4'hF;
        #1 rst = 1'b0;
        #10;
        total_cnt++;
        if ({rdata_o, rvalid_o, ack_o, err_o, stallreq_o} !== 36'h0) begin
            $display("FAIL reset_outputs: got rdata=%h rvalid=%b ack=%b err=%b stall=%b want all 0",
                     rdata_o, rvalid_o, ack_o, err_o, stallreq_o);
        end else pass_cnt++;
        tick;
        total_cnt++;
        if ({rdata_o, rvalid_o, ack_o, err_o, stallreq_o} !== 36'h0) begin
            $display("FAIL reset_held_edge: got rdata=%h rvalid=%b ack=%b err=%b stall=%b want all 0",
                     rdata_o, rvalid_o, ack_o, err_o, stallreq_o);
        end else pass_cnt++;
        idle_inputs;
        #3 rst = 1'b1;
        ref_rdata = 32'h0;
        tick;
    endtask

    task automatic test_directed;
        op_t ops[13];
        logic [6:0]  tv;
        logic [31:0] rd;
        logic [6:0]  exp_tv;
        ops = '{
            '{2'b10, 12'h010, 4'hF, 32'hDEADBEEF, 32'h00000000},
            '{2'b01, 12'h010, 4'hF, 32'h0,        32'hDEADBEEF},
            '{2'b10, 12'h020, 4'hF, 32'h11223344, 32'hDEADBEEF},
            '{2'b10, 12'h020, 4'h1, 32'h000000AA, 32'hDEADBEEF},
            '{2'b01, 12'h020, 4'hF, 32'h0,        32'h112233AA},
            '{2'b01, 12'h020, 4'h6, 32'h0,        32'h00223300},
            '{2'b10, 12'h000, 4'hF, 32'h12345678, 32'h00223300},
            '{2'b10, 12'hFFC, 4'hF, 32'hCAFEF00D, 32'h00223300},
            '{2'b01, 12'hFFC, 4'hF, 32'h0,        32'hCAFEF00D},
            '{2'b01, 12'h000, 4'hF, 32'h0,        32'h12345678},
            '{2'b01, 12'h010, 4'hF, 32'h0,        32'hDEADBEEF},
            '{2'b10, 12'h010, 4'hF, 32'h0BADF00D, 32'hDEADBEEF},
            '{2'b01, 12'h010, 4'hF, 32'h0,        32'h0BADF00D}
        };
        for (int i = 0; i < 13; i++) begin
            if (ops[i].rw == 2'b10) ref_store(ops[i].addr, ops[i].sel, ops[i].data);
            else void'(ref_load(ops[i].addr, ops[i].sel));
            exp_tv = {3'b110, 3'b001, ops[i].rw == 2'b01};
            do_op(ops[i].rw, ops[i].addr, ops[i].sel, ops[i].data, tv, rd);
            total_cnt++;
            if (tv !== exp_tv) begin
                $display("FAIL directed_timing[%0d]: got %b want %b", i, tv, exp_tv);
            end else pass_cnt++;
            total_cnt++;
            if (rd !== ops[i].exp) begin
                $display("FAIL directed_rdata[%0d]: got %h want %h", i, rd, ops[i].exp);
            end else pass_cnt++;
        end
    endtask

    task automatic test_errors;
        logic [1:0] rws  [3] = '{2'b11, 2'b01, 2'b10};
        logic [3:0] sels [3] = '{4'hF, 4'h0, 4'h0};
        for (int i = 0; i < 3; i++) begin
            mem_rw_i   = rws[i];
            mem_sel_i  = sels[i];
            mem_addr_i = 12'h010;
            mem_data_i = 32'hFFFFFFFF;
            #1;
            total_cnt++;
            if (stallreq_o !== 1'b0) begin
                $display("FAIL err_stall[%0d]: got %b want 0", i, stallreq_o);
            end else pass_cnt++;
            tick;
            total_cnt++;
            if ({err_o, ack_o, rvalid_o, stallreq_o} !== 4'b1000) begin
                $display("FAIL err_pulse[%0d]: got err/ack/rvalid/stall=%b want 1000", i,
                         {err_o, ack_o, rvalid_o, stallreq_o});
            end else pass_cnt++;
            idle_inputs;
            tick;
            total_cnt++;
            if ({err_o, rdata_o} !== {1'b0, ref_rdata}) begin
                $display("FAIL err_after[%0d]: got err=%b rdata=%h want err=0 rdata=%h", i,
                         err_o, rdata_o, ref_rdata);
            end else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_op;
        logic [6:0]  tv;
        logic [31:0] rd;
        logic [31:0] exp;
        // Reset during LOAD
        mem_rw_i = 2'b01; mem_addr_i = 12'h010; mem_sel_i = 4'hF;
        tick;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({rdata_o, rvalid_o, ack_o, err_o, stallreq_o} !== 36'h0) begin
            $display("FAIL rst_in_load: got rdata=%h rvalid=%b ack=%b err=%b stall=%b want all 0",
                     rdata_o, rvalid_o, ack_o, err_o, stallreq_o);
        end else pass_cnt++;
        ref_rdata = 32'h0;
        tick;
        idle_inputs;
        #2 rst = 1'b1;
        tick;
        exp = ref_load(12'h010, 4'hF);
        do_op(2'b01, 12'h010, 4'hF, 32'h0, tv, rd);
        total_cnt++;
        if ({tv, rd} !== {7'b1100011, exp}) begin
            $display("FAIL load_after_rst: got tv=%b rdata=%h want tv=1100011 rdata=%h", tv, rd, exp);
        end else pass_cnt++;
        // Reset during STORE: the write must be abandoned
        mem_rw_i = 2'b10; mem_addr_i = 12'h010; mem_sel_i = 4'hF; mem_data_i = 32'h55555555;
        tick;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({ack_o, rvalid_o, stallreq_o} !== 3'b000) begin
            $display("FAIL rst_in_store: got ack/rvalid/stall=%b want 000", {ack_o, rvalid_o, stallreq_o});
        end else pass_cnt++;
        ref_rdata = 32'h0;
        tick;
        idle_inputs;
        #2 rst = 1'b1;
        tick;
        exp = ref_load(12'h010, 4'hF);
        do_op(2'b01, 12'h010, 4'hF, 32'h0, tv, rd);
        total_cnt++;
        if (rd !== exp) begin
            $display("FAIL store_abandoned: got %h want %h", rd, exp);
        end else pass_cnt++;
    endtask

    task automatic test_held_load;
        logic [6:0]  tv;
        logic [31:0] rd;
        logic [5:0]  stall_v, ack_v, rv_v;
        logic [31:0] exp;
        ref_store(12'h004, 4'hF, 32'h0A0B0C0D);
        do_op(2'b10, 12'h004, 4'hF, 32'h0A0B0C0D, tv, rd);
        exp = ref_load(12'h004, 4'hF);
        mem_rw_i = 2'b01; mem_addr_i = 12'h004; mem_sel_i = 4'hF;
        #1;
        for (int k = 0; k < 6; k++) begin
            stall_v[5-k] = stallreq_o;
            ack_v[5-k]   = ack_o;
            rv_v[5-k]    = rvalid_o;
            if (k == 5) idle_inputs;
            tick;
        end
        total_cnt++;
        if (stall_v !== 6'b110110) begin
            $display("FAIL held_stall: got %b want 110110", stall_v);
        end else pass_cnt++;
        total_cnt++;
        if ({ack_v, rv_v} !== {6'b001001, 6'b001001}) begin
            $display("FAIL held_ack_rvalid: got ack=%b rvalid=%b want 001001/001001", ack_v, rv_v);
        end else pass_cnt++;
        total_cnt++;
        if (rdata_o !== exp) begin
            $display("FAIL held_rdata: got %h want %h", rdata_o, exp);
        end else pass_cnt++;
    endtask

    task automatic test_random;
        logic [9:0]  pool [8];
        logic [6:0]  tv;
        logic [31:0] rd;
        logic [31:0] exp;
        logic [1:0]  rw;
        logic [11:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 10'($urandom_range(0, 1023));
            data = $urandom;
            ref_store({pool[i], 2'b00}, 4'hF, data);
            do_op(2'b10, {pool[i], 2'b00}, 4'hF, data, tv, rd);
        end
        for (int n = 0; n < 40; n++) begin
            rw   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            addr = {pool[$urandom_range(0, 7)], 2'($urandom_range(0, 3))};
            sel  = 4'($urandom_range(1, 15));
            data = $urandom;
            if (rw == 2'b10) ref_store(addr, sel, data);
            exp = (rw == 2'b01) ? ref_load(addr, sel) : ref_rdata;
            do_op(rw, addr, sel, data, tv, rd);
            total_cnt++;
            if ({tv, rd} !== {3'b110, 3'b001, rw == 2'b01, exp}) begin
                $display("FAIL random[%0d] rw=%b addr=%h sel=%h: got tv=%b rdata=%h want tv=%b rdata=%h",
                         n, rw, addr, sel, tv, rd, {3'b110, 3'b001, rw == 2'b01}, exp);
            end else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_errors;
        test_reset_mid_op;
        test_held_load;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
